// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Main control unit for a multicycle RV32 subset (lw, sw, R-type, I-type ALU,
//   beq, jal, lui). A Moore FSM sequences each instruction. Separate
//   combinational decoders produce ImmSrc from the opcode and ALUControl from
//   the state's ALU operation class.
//
// Ports
//   clk         in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   op[6:0]     in   opcode field of the instruction register
//   funct3[2:0] in   instruction bits 14:12
//   funct7b5    in   instruction bit 30
//   Zero        in   ALU zero flag
//   PCWrite     out  PC load enable
//   AdrSrc      out  memory address select (0 PC, 1 result)
//   MemWrite    out  data memory write strobe
//   IRWrite     out  instruction / OldPC register load enable
//   ResultSrc   out  result select (ALUOut, Data, ALUResult, ImmExt)
//   ALUSrcA     out  ALU A select (PC, OldPC, rs1)
//   ALUSrcB     out  ALU B select (rs2, ImmExt, 4)
//   ALUControl  out  ALU operation
//   ImmSrc      out  immediate format
//   RegWrite    out  register file write enable
//   State[3:0]  out  current state code (debug)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t     state_reg, state_next;
  logic       pcupdate, branch, irwrite_int, memwrite_int, regwrite_int;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_FETCH;
    else          state_reg <= state_next;
  end

  // Next state and Moore outputs. Unused codes 12-15 fall into the default
  // branch: all outputs 0 and return to FETCH.
  always_comb begin
    state_next   = S_FETCH;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_int  = 1'b0;
    memwrite_int = 1'b0;
    regwrite_int = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    aluop        = 2'b00;
    case (state_reg)
      S_FETCH: begin
        state_next  = S_DECODE;
        irwrite_int = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        pcupdate    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        regwrite_int = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        memwrite_int = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        aluop      = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        aluop      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_int = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pcupdate   = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc    = 2'b11;
        regwrite_int = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // The state register is already FETCH while reset is held, so only the
  // write strobes need masking to keep the datapath quiet during reset.
  assign PCWrite  = reset_n & (pcupdate | (branch & Zero));
  assign IRWrite  = reset_n & irwrite_int;
  assign MemWrite = reset_n & memwrite_int;
  assign RegWrite = reset_n & regwrite_int;
  assign State    = state_reg;

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = 3'b000;
      OP_SW:       ImmSrc = 3'b001;
      OP_BEQ:      ImmSrc = 3'b010;
      OP_JAL:      ImmSrc = 3'b011;
      OP_LUI:      ImmSrc = 3'b100;
      default:     ImmSrc = 3'b000;
    endcase
  end

  // op[5] separates R-type from I-type, so only R-type with funct7b5 subtracts.
  always_comb begin
    case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b001:  ALUControl = 3'b100;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed instruction stream against a sequence/table model of the
//   controller. Each instruction class maps to its full list of state codes.
//   Each state code maps to the output fields it must drive. A negedge
//   compare process checks every output on every cycle. Per-state snapshots
//   of the DUT outputs are then pinned against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] State;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .State(State)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  logic chk = 1'b0;
  int   model_state = 0;

  // Per-state snapshots of selected DUT outputs, for the literal checks.
  logic [2:0] snap_aluc [16];
  logic [2:0] snap_imm  [16];
  logic [2:0] snap_rs   [16];
  logic       snap_pcw  [16];
  logic       snap_regw [16];
  logic       snap_memw [16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 3'd0;
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111:             return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_aluc(input logic [1:0] aop, input logic [2:0] f3,
                                          input logic o5, input logic f7);
    if (aop == 2'b01) return 3'd1;
    if (aop != 2'b10) return 3'd0;
    case (f3)
      3'b000:  return (o5 && f7) ? 3'd1 : 3'd0;
      3'b001:  return 3'd4;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Whole-instruction state lists, one per instruction class.
  task automatic get_seq(input logic [6:0] o, output int q[$]);
    case (o)
      7'b0000011: q = {0, 1, 2, 3, 4};
      7'b0100011: q = {0, 1, 2, 5};
      7'b0110011: q = {0, 1, 6, 8};
      7'b0010011: q = {0, 1, 7, 8};
      7'b1101111: q = {0, 1, 10, 8};
      7'b1100011: q = {0, 1, 9};
      7'b0110111: q = {0, 1, 11};
      default:    q = {0, 1};
    endcase
  endtask

  // Expected output fields for the current model state.
  logic       e_pcu, e_br, e_irw, e_adr, e_mw, e_rw;
  logic [1:0] e_rs, e_sa, e_sb, e_aop;

  always @(negedge clk) begin
    if (chk) begin
      {e_pcu, e_br, e_irw, e_adr, e_mw, e_rw} = 6'b0;
      {e_rs, e_sa, e_sb, e_aop} = 8'b0;
      case (model_state)
        0:  begin e_irw = 1; e_sb = 2'b10; e_rs = 2'b10; e_pcu = 1; end
        1:  begin e_sa = 2'b01; e_sb = 2'b01; end
        2:  begin e_sa = 2'b10; e_sb = 2'b01; end
        3:  e_adr = 1;
        4:  begin e_rs = 2'b01; e_rw = 1; end
        5:  begin e_adr = 1; e_mw = 1; end
        6:  begin e_sa = 2'b10; e_aop = 2'b10; end
        7:  begin e_sa = 2'b10; e_sb = 2'b01; e_aop = 2'b10; end
        8:  e_rw = 1;
        9:  begin e_sa = 2'b10; e_aop = 2'b01; e_br = 1; end
        10: begin e_sa = 2'b01; e_sb = 2'b10; e_pcu = 1; end
        11: begin e_rs = 2'b11; e_rw = 1; end
        default: ;
      endcase
      if (!reset_n) begin
        {e_pcu, e_br, e_irw, e_mw, e_rw} = 5'b0;
      end
      check("State",      8'(State),      8'(model_state));
      check("PCWrite",    8'(PCWrite),    8'(e_pcu | (e_br & Zero)));
      check("AdrSrc",     8'(AdrSrc),     8'(e_adr));
      check("MemWrite",   8'(MemWrite),   8'(e_mw));
      check("IRWrite",    8'(IRWrite),    8'(e_irw));
      check("ResultSrc",  8'(ResultSrc),  8'(e_rs));
      check("ALUSrcA",    8'(ALUSrcA),    8'(e_sa));
      check("ALUSrcB",    8'(ALUSrcB),    8'(e_sb));
      check("ALUControl", 8'(ALUControl), 8'(exp_aluc(e_aop, funct3, op[5], funct7b5)));
      check("ImmSrc",     8'(ImmSrc),     8'(exp_imm(op)));
      check("RegWrite",   8'(RegWrite),   8'(e_rw));
      snap_aluc[State] = ALUControl;
      snap_imm[State]  = ImmSrc;
      snap_rs[State]   = {1'b0, ResultSrc};
      snap_pcw[State]  = PCWrite;
      snap_regw[State] = RegWrite;
      snap_memw[State] = MemWrite;
    end
  end

  // Called at 1 time unit after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    int q[$];
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    for (int i = 0; i < 16; i++) begin
      snap_aluc[i] = 'x; snap_imm[i] = 'x; snap_rs[i] = 'x;
      snap_pcw[i] = 1'bx; snap_regw[i] = 1'bx; snap_memw[i] = 1'bx;
    end
    get_seq(o, q);
    foreach (q[i]) begin
      model_state = q[i];
      @(posedge clk); #1;
    end
    $display("[TB] op=%b funct3=%b funct7b5=%b Zero=%b cycles=%0d", o, f3, f7, z, q.size());
  endtask

  initial begin
    // Reset held across edges: FETCH with strobes masked.
    chk = 1'b1; model_state = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_State",   8'(State),   8'd0);
    check("rst_IRWrite", 8'(IRWrite), 8'd0);
    check("rst_PCWrite", 8'(PCWrite), 8'd0);
    reset_n = 1'b1;
    #1;
    check("rel_IRWrite", 8'(IRWrite), 8'd1);
    check("rel_PCWrite", 8'(PCWrite), 8'd1);

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);   // lw
    check("lw_MEMWB_ResultSrc", 8'(snap_rs[4]), 8'd1);
    check("lw_MEMWB_RegWrite",  8'(snap_regw[4]), 8'd1);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1);   // sw
    check("sw_MEMWRITE_MemWrite", 8'(snap_memw[5]), 8'd1);
    check("sw_ImmSrc",            8'(snap_imm[5]), 8'd1);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b1);   // sub
    check("sub_ALUControl", 8'(snap_aluc[6]), 8'd1);
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);   // add
    check("add_ALUControl", 8'(snap_aluc[6]), 8'd0);
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0);   // slt
    check("slt_ALUControl", 8'(snap_aluc[6]), 8'd5);
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0);   // or
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0);   // and
    run_instr(7'b0110011, 3'b100, 1'b0, 1'b0);   // unsupported funct3 -> add
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);   // addi, funct7b5=1
    check("addi_ALUControl", 8'(snap_aluc[7]), 8'd0);
    run_instr(7'b0010011, 3'b001, 1'b0, 1'b0);   // slli
    check("slli_ALUControl", 8'(snap_aluc[7]), 8'd4);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);   // beq taken
    check("beq_taken_PCWrite", 8'(snap_pcw[9]), 8'd1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);   // beq not taken
    check("beq_nt_PCWrite", 8'(snap_pcw[9]), 8'd0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);   // jal
    check("jal_PCWrite", 8'(snap_pcw[10]), 8'd1);
    check("jal_ImmSrc",  8'(snap_imm[10]), 8'd3);
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0);   // lui
    check("lui_ResultSrc", 8'(snap_rs[11]), 8'd3);
    check("lui_RegWrite",  8'(snap_regw[11]), 8'd1);
    check("lui_ImmSrc",    8'(snap_imm[11]), 8'd4);
    run_instr(7'b0000000, 3'b000, 1'b1, 1'b1);   // illegal
    check("ill_DECODE_RegWrite", 8'(snap_regw[1]), 8'd0);
    run_instr(7'b1110011, 3'b000, 1'b0, 1'b1);   // illegal

    // lw aborted by a reset pulse between edges while in MEMWB.
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_state = i;
      @(posedge clk); #1;
    end
    model_state = 4;
    check("abort_pre_RegWrite", 8'(RegWrite), 8'd1);
    #2;
    model_state = 0;
    reset_n = 1'b0;
    #1;
    check("abort_State",    8'(State),    8'd0);
    check("abort_RegWrite", 8'(RegWrite), 8'd0);
    @(posedge clk); #1;
    check("abort_hold_State", 8'(State), 8'd0);
    reset_n = 1'b1;
    $display("[TB] lw aborted by reset in MEMWB");
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);   // sub after recovery
    check("rec_sub_ALUControl", 8'(snap_aluc[6]), 8'd1);

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  opcode from the instruction register; stable from DECODE onward.
REQ-005 funct3  input  3  instruction register bits 14:12.
REQ-006 funct7b5  input  1  instruction register bit 30.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 PCWrite  output  1  PC register load enable.
REQ-009 AdrSrc  output  1  memory address select: 0 = PC, 1 = result.
REQ-010 MemWrite  output  1  data memory write strobe.
REQ-011 IRWrite  output  1  instruction and OldPC register load enable.
REQ-012 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
REQ-013 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-014 ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-015 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt.
REQ-016 ImmSrc  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-017 RegWrite  output  1  register file write enable.
REQ-018 State  output  4  current state code, for debug and verification.

Function
REQ-019 The FSM is Moore with a 4-bit registered state: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11; codes 12-15 go to FETCH next cycle with all write enables 0.
REQ-020 Transitions from FETCH, MEMWB, MEMWRITE, ALUWB, BEQ and LUI:
- FETCH -> DECODE.
- MEMWB, MEMWRITE, ALUWB, BEQ, LUI -> FETCH.
REQ-021 Transitions from DECODE, by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- 0110111 -> LUI.
- any other opcode -> FETCH, with no register or memory write.
REQ-022 Transitions from MEMADR and the execute/jump states:
- MEMADR: op=0000011 -> MEMREAD; otherwise -> MEMWRITE.
- MEMREAD -> MEMWB.
- EXECUTER, EXECUTEI, JAL -> ALUWB.
REQ-023 Cycles per instruction, counted from FETCH: lw 5; sw, R-type, I-type and jal 4; beq and lui 3; illegal opcode 2.
REQ-024 Per-state outputs (any field not listed is 0):
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- LUI: ResultSrc=11, RegWrite=1.
REQ-025 PCWrite SHALL equal PCUpdate | (Branch & Zero), evaluated combinationally in the same cycle.
REQ-026 ImmSrc SHALL be decoded combinationally from op in every state:
- lw and I-type -> 000; sw -> 001; beq -> 010; jal -> 011; lui -> 100; any other opcode -> 000.
REQ-027 ALUControl SHALL be decoded combinationally from ALUOp:
- ALUOp 00 or 11 -> 000; ALUOp 01 -> 001.
- ALUOp 10, by funct3: 000 -> 001 when {op[5], funct7b5}=11, otherwise 000; 001 -> 100; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-028 All outputs SHALL be fully assigned in every state; no latches and no X values.

Reset
REQ-029 When reset_n falls, State SHALL become FETCH immediately, without waiting for clk.
REQ-030 While reset_n=0, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0; all other outputs take their FETCH values.
REQ-031 On the first rising clk edge after reset_n rises, FETCH SHALL execute normally with IRWrite=1 and PCWrite=1.
REQ-032 Reset asserted in any state, mid-instruction, SHALL abort the instruction with no further write strobes.

Verification
REQ-033 lw (op=0000011) -> State 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in MEMWB; ImmSrc=000.
REQ-034 sw (op=0100011) -> State 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in MEMWRITE; ImmSrc=001.
REQ-035 sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; addi with funct7b5=1 -> ALUControl=000 in EXECUTEI.
REQ-036 beq, Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both cases return to FETCH.
REQ-037 lui -> State 0,1,11,0, with ResultSrc=11, RegWrite=1 and ImmSrc=100 in LUI; op=0000000 -> State 0,1,0 with no write strobes.
REQ-038 reset_n pulsed low between clock edges during MEMWB -> State=0 and RegWrite=0 immediately, before the next clk edge.
